// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//
// Execute-stage controller that resolves one conditional branch, JAL or JALR
// at a time. Decode hands over a request on a valid/ready handshake. The
// operands are captured, the condition and target are evaluated for one
// cycle, and the result goes out as one of these:
//   - a fetch redirect with a flush,
//   - a plain "done",
//   - a misaligned-target exception.
// Two wrap-around counters keep statistics on conditional branches.
//
// Parameters
//   XLEN   operand / PC width
//   CNT_W  statistics counter width
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o  request handshake from decode (ready only in IDLE)
//   op_i, func3_i        transfer kind and branch condition
//   rs1_i, rs2_i         source operands
//   pc_i, imm_i          instruction PC and sign-extended offset
//   redirect_valid_o/ready_i, redirect_pc_o  fetch redirect handshake
//   flush_o, done_o, link_valid_o, misaligned_o  one-cycle result pulses
//   link_data_o          pc + 4 for JAL/JALR
//   branch_cnt_o, taken_cnt_o  resolved / taken conditional branch counts
`timescale 1ns/1ps

module branch_resolve_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       op_i,
  input  logic [2:0]       func3_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic             redirect_valid_o,
  input  logic             redirect_ready_i,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_o,
  output logic             done_o,
  output logic             link_valid_o,
  output logic [XLEN-1:0]  link_data_o,
  output logic             misaligned_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_JAL    = 2'b01;
  localparam logic [1:0] OP_JALR   = 2'b10;

  state_t state_q, state_d;

  logic [1:0]      op_q;
  logic [2:0]      func3_q;
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q;

  logic            eq, lt, ltu, cond_true, func3_valid, is_branch, is_jump, taken;
  logic [XLEN-1:0] branch_target, jalr_sum, target;

  logic             req_ready_d, redirect_valid_d, flush_d, done_d, link_valid_d, misaligned_d;
  logic [XLEN-1:0]  redirect_pc_d, link_data_d;
  logic [CNT_W-1:0] branch_cnt_d, taken_cnt_d;

  // State register. A reset in any state abandons the request in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the request when it is accepted in IDLE. Decode may change its
  // operands freely afterwards because EVAL only looks at these copies.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= '0;
      func3_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
    end else if (state_q == IDLE && req_valid_i) begin
      op_q    <= op_i;
      func3_q <= func3_i;
      rs1_q   <= rs1_i;
      rs2_q   <= rs2_i;
      pc_q    <= pc_i;
      imm_q   <= imm_i;
    end
  end

  // Condition and target evaluation on the captured operands. Reserved
  // func3 codes and the reserved op fall out as not taken. The JALR target
  // drops bit 0, so bit 1 alone decides misalignment.
  always_comb begin
    eq  = (rs1_q == rs2_q);
    lt  = ($signed(rs1_q) < $signed(rs2_q));
    ltu = (rs1_q < rs2_q);

    cond_true   = 1'b0;
    func3_valid = 1'b1;
    case (func3_q)
      3'b000:  cond_true = eq;
      3'b001:  cond_true = !eq;
      3'b100:  cond_true = lt;
      3'b101:  cond_true = !lt;
      3'b110:  cond_true = ltu;
      3'b111:  cond_true = !ltu;
      default: func3_valid = 1'b0;
    endcase

    is_branch = (op_q == OP_BRANCH);
    is_jump   = (op_q == OP_JAL) || (op_q == OP_JALR);
    taken     = is_jump || (is_branch && cond_true);

    branch_target = pc_q + imm_q;
    jalr_sum      = rs1_q + imm_q;
    target        = (op_q == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : branch_target;
  end

  // Next-state and next-output logic. Pulses default to zero so that each
  // one lasts exactly one cycle after the EVAL exit edge. The redirect
  // outputs default to holding their value, which keeps them stable while
  // fetch stalls.
  always_comb begin
    state_d          = state_q;
    flush_d          = 1'b0;
    done_d           = 1'b0;
    link_valid_d     = 1'b0;
    misaligned_d     = 1'b0;
    redirect_valid_d = redirect_valid_o;
    redirect_pc_d    = redirect_pc_o;
    link_data_d      = link_data_o;
    branch_cnt_d     = branch_cnt_o;
    taken_cnt_d      = taken_cnt_o;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = EVAL;
        end
      end

      EVAL: begin
        if (is_branch && func3_valid) begin
          branch_cnt_d = branch_cnt_o + CNT_W'(1);
        end
        if (is_branch && taken) begin
          taken_cnt_d = taken_cnt_o + CNT_W'(1);
        end

        if (taken && target[1]) begin
          misaligned_d = 1'b1;
          state_d      = IDLE;
        end else if (taken) begin
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target;
          state_d          = REDIRECT;
          if (is_jump) begin
            link_valid_d = 1'b1;
            link_data_d  = pc_q + XLEN'(4);
          end
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      REDIRECT: begin
        if (redirect_ready_i) begin
          redirect_valid_d = 1'b0;
          state_d          = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // Output registers. Ready is registered from the next state so that it
  // is high exactly while the FSM sits in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_ready_o      <= 1'b1;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      flush_o          <= 1'b0;
      done_o           <= 1'b0;
      link_valid_o     <= 1'b0;
      link_data_o      <= '0;
      misaligned_o     <= 1'b0;
      branch_cnt_o     <= '0;
      taken_cnt_o      <= '0;
    end else begin
      req_ready_o      <= req_ready_d;
      redirect_valid_o <= redirect_valid_d;
      redirect_pc_o    <= redirect_pc_d;
      flush_o          <= flush_d;
      done_o           <= done_d;
      link_valid_o     <= link_valid_d;
      link_data_o      <= link_data_d;
      misaligned_o     <= misaligned_d;
      branch_cnt_o     <= branch_cnt_d;
      taken_cnt_o      <= taken_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed testbench for branch_resolve_ctrl. It uses CNT_W=4 so that the
// statistics counters wrap within a short run.
`timescale 1ns/1ps

module tb_branch_resolve_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk_i;
  logic             rst_ni;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       op_i;
  logic [2:0]       func3_i;
  logic [XLEN-1:0]  rs1_i, rs2_i, pc_i, imm_i;
  logic             redirect_valid_o;
  logic             redirect_ready_i;
  logic [XLEN-1:0]  redirect_pc_o;
  logic             flush_o, done_o, link_valid_o, misaligned_o;
  logic [XLEN-1:0]  link_data_o;
  logic [CNT_W-1:0] branch_cnt_o, taken_cnt_o;

  int checkCount = 0;
  int errorCount = 0;

  branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .op_i             (op_i),
    .func3_i          (func3_i),
    .rs1_i            (rs1_i),
    .rs2_i            (rs2_i),
    .pc_i             (pc_i),
    .imm_i            (imm_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_ready_i (redirect_ready_i),
    .redirect_pc_o    (redirect_pc_o),
    .flush_o          (flush_o),
    .done_o           (done_o),
    .link_valid_o     (link_valid_o),
    .link_data_o      (link_data_o),
    .misaligned_o     (misaligned_o),
    .branch_cnt_o     (branch_cnt_o),
    .taken_cnt_o      (taken_cnt_o)
  );

  // Free-running 10 ns clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports a mismatch
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one request and walk it to the negedge after the EVAL exit
  // edge (T1). Operands are scrambled right after acceptance.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] pc, input logic [31:0] imm);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    op_i = op; func3_i = f3; rs1_i = rs1; rs2_i = rs2; pc_i = pc; imm_i = imm;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    rs1_i = $urandom; rs2_i = $urandom; pc_i = $urandom; imm_i = $urandom;
    @(negedge clk_i);
    checkOutput("eval_ready_low", req_ready_o, 1'b0);
    @(negedge clk_i);
  endtask

  // Complete a pending redirect with ready high for one edge
  task automatic retireRedirect();
    redirect_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    redirect_ready_i = 1'b0;
    @(negedge clk_i);
    checkOutput("retire_valid", redirect_valid_o, 1'b0);
    checkOutput("retire_ready", req_ready_o, 1'b1);
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    redirect_ready_i = 1'b0;
    op_i = '0; func3_i = '0; rs1_i = '0; rs2_i = '0; pc_i = '0; imm_i = '0;

    // Reset state
    #12;
    checkOutput("rst_ready", req_ready_o, 1'b1);
    checkOutput("rst_rvalid", redirect_valid_o, 1'b0);
    checkOutput("rst_rpc", redirect_pc_o, 32'h0);
    checkOutput("rst_bcnt", branch_cnt_o, 4'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // BEQ taken, fetch stalls for three cycles
    applyStimulus(2'b00, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
    checkOutput("beq_flush", flush_o, 1'b1);
    checkOutput("beq_rvalid", redirect_valid_o, 1'b1);
    checkOutput("beq_rpc", redirect_pc_o, 32'h120);
    checkOutput("beq_done", done_o, 1'b0);
    checkOutput("beq_link", link_valid_o, 1'b0);
    checkOutput("beq_bcnt", branch_cnt_o, 4'd1);
    checkOutput("beq_tcnt", taken_cnt_o, 4'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("stall_rvalid", redirect_valid_o, 1'b1);
      checkOutput("stall_rpc", redirect_pc_o, 32'h120);
      checkOutput("stall_flush", flush_o, 1'b0);
      checkOutput("stall_ready", req_ready_o, 1'b0);
    end
    retireRedirect();

    // BLT with -1 < 1 is taken
    applyStimulus(2'b00, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10);
    checkOutput("blt_flush", flush_o, 1'b1);
    checkOutput("blt_rpc", redirect_pc_o, 32'h210);
    retireRedirect();

    // BLTU with 0xFFFFFFFF < 1 is not taken
    applyStimulus(2'b00, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10);
    checkOutput("bltu_done", done_o, 1'b1);
    checkOutput("bltu_flush", flush_o, 1'b0);
    checkOutput("bltu_rvalid", redirect_valid_o, 1'b0);
    checkOutput("bltu_ready", req_ready_o, 1'b1);

    // BGE is not taken, BGEU is taken
    applyStimulus(2'b00, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10);
    checkOutput("bge_done", done_o, 1'b1);
    checkOutput("bge_flush", flush_o, 1'b0);
    applyStimulus(2'b00, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h8);
    checkOutput("bgeu_flush", flush_o, 1'b1);
    checkOutput("bgeu_rpc", redirect_pc_o, 32'h308);
    checkOutput("bgeu_bcnt", branch_cnt_o, 4'd5);
    checkOutput("bgeu_tcnt", taken_cnt_o, 4'd3);
    retireRedirect();

    // JALR whose target has bit 1 set after bit 0 is cleared
    applyStimulus(2'b10, 3'b000, 32'h1001, 32'h0, 32'h40, 32'h2);
    checkOutput("jalr_mis", misaligned_o, 1'b1);
    checkOutput("jalr_flush", flush_o, 1'b0);
    checkOutput("jalr_rvalid", redirect_valid_o, 1'b0);
    checkOutput("jalr_link", link_valid_o, 1'b0);
    checkOutput("jalr_ready", req_ready_o, 1'b1);
    checkOutput("jalr_bcnt", branch_cnt_o, 4'd5);
    @(negedge clk_i);
    checkOutput("jalr_mis_pulse", misaligned_o, 1'b0);

    // A misaligned taken BEQ still counts as taken
    applyStimulus(2'b00, 3'b000, 32'd7, 32'd7, 32'h2, 32'h0);
    checkOutput("beqmis_mis", misaligned_o, 1'b1);
    checkOutput("beqmis_bcnt", branch_cnt_o, 4'd6);
    checkOutput("beqmis_tcnt", taken_cnt_o, 4'd4);

    // JAL with a wrapping target
    applyStimulus(2'b01, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20);
    checkOutput("jal_flush", flush_o, 1'b1);
    checkOutput("jal_rpc", redirect_pc_o, 32'h0000_0010);
    checkOutput("jal_link", link_valid_o, 1'b1);
    checkOutput("jal_ldata", link_data_o, 32'hFFFF_FFF4);
    checkOutput("jal_bcnt", branch_cnt_o, 4'd6);
    checkOutput("jal_tcnt", taken_cnt_o, 4'd4);
    @(negedge clk_i);
    checkOutput("jal_link_pulse", link_valid_o, 1'b0);
    checkOutput("jal_flush_pulse", flush_o, 1'b0);
    retireRedirect();

    // Back-to-back: func3=010 then op=11, valid held high throughout
    @(negedge clk_i);
    req_valid_i = 1'b1;
    op_i = 2'b00; func3_i = 3'b010; rs1_i = 32'd3; rs2_i = 32'd3; pc_i = 32'h80; imm_i = 32'h4;
    @(posedge clk_i);
    #1;
    op_i = 2'b11; func3_i = 3'b000;
    @(negedge clk_i);
    checkOutput("b2b_eval_ready", req_ready_o, 1'b0);
    @(negedge clk_i);
    checkOutput("f3rsv_done", done_o, 1'b1);
    checkOutput("f3rsv_flush", flush_o, 1'b0);
    checkOutput("b2b_ready", req_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("b2b_second_eval", req_ready_o, 1'b0);
    checkOutput("b2b_done_gap", done_o, 1'b0);
    @(negedge clk_i);
    checkOutput("op11_done", done_o, 1'b1);
    checkOutput("op11_flush", flush_o, 1'b0);
    checkOutput("op11_bcnt", branch_cnt_o, 4'd6);
    checkOutput("op11_tcnt", taken_cnt_o, 4'd4);

    // Reset while a redirect is pending
    applyStimulus(2'b00, 3'b000, 32'd1, 32'd1, 32'h500, 32'h40);
    checkOutput("pre_rst_rvalid", redirect_valid_o, 1'b1);
    checkOutput("pre_rst_tcnt", taken_cnt_o, 4'd5);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("arst_rvalid", redirect_valid_o, 1'b0);
    checkOutput("arst_ready", req_ready_o, 1'b1);
    checkOutput("arst_rpc", redirect_pc_o, 32'h0);
    checkOutput("arst_tcnt", taken_cnt_o, 4'd0);
    checkOutput("arst_flush", flush_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // BNE after reset resolves normally
    applyStimulus(2'b00, 3'b001, 32'd1, 32'd2, 32'h600, 32'h100);
    checkOutput("bne_flush", flush_o, 1'b1);
    checkOutput("bne_rpc", redirect_pc_o, 32'h700);
    checkOutput("bne_bcnt", branch_cnt_o, 4'd1);
    retireRedirect();

    // Counter wrap: reset, then 17 taken branches on a 4-bit counter
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(2'b00, 3'b000, 32'd9, 32'd9, 32'h1000, 32'h10);
      retireRedirect();
    end
    checkOutput("wrap_tcnt", taken_cnt_o, 4'd1);
    checkOutput("wrap_bcnt", branch_cnt_o, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Watchdog so that the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
